tc_block_scheduler: RTL and testbench
=====================================

Name: tc_block_scheduler

Overview:
- Controller for the transform-coding front end.
- Accepts one 16x16 luma macroblock per handshake and pulses a load strobe so the datapath captures it.
- Sequences the 16 constituent 4x4 blocks to the downstream 4x4 transform stage, one block per valid/ready handshake.
- Tracks blocks in flight with a credit counter, supports raster or H.264 double-Z scan order, and signals macroblock completion once every issued block has returned its transform-done pulse.

Parameters:
- MAX_OUTSTANDING, 2, maximum issued-but-not-completed blocks; legal range 1..15.
- CNT_W, $clog2(MAX_OUTSTANDING+1), width of the credit counter; derived, not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- mb_valid  in  1  upstream has a macroblock ready.
- mb_ready  out  1  scheduler can accept a macroblock.
- order_sel  in  1  scan order: 0 = raster, 1 = double-Z; sampled on the mb handshake.
- mb_load  out  1  one-cycle strobe; the datapath captures the 16x16 block.
- blk_valid  out  1  block descriptor valid.
- blk_ready  in  1  transform stage accepts the descriptor.
- blk_idx  out  4  scan position 0..15 of the current descriptor.
- blk_start  out  8  pixel offset of the block's top-left sample (row*16 + col).
- blk_first  out  1  descriptor is scan position 0.
- blk_last  out  1  descriptor is scan position 15.
- xform_done  in  1  one-cycle pulse per completed block, in order.
- mb_done  out  1  one-cycle pulse when the macroblock is fully processed.
- busy  out  1  state is not IDLE.
- err_sticky  out  1  set on a protocol violation; cleared only by reset.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE; blk counter k=0, credit=0, order register=0.
  - All outputs 0 except mb_ready=1. err_sticky is cleared.
  - Reset mid-macroblock abandons it; no mb_done is produced.
- States: IDLE, LOAD, ISSUE, DRAIN.
- IDLE:
  - mb_ready=1.
  - On mb_valid&&mb_ready: latch order_sel, go to LOAD.
- LOAD: single cycle.
  - mb_load=1, mb_ready=0, k=0.
  - Next state is ISSUE.
- ISSUE:
  - blk_valid=1 iff credit < MAX_OUTSTANDING.
  - blk_idx=k; blk_first=(k==0); blk_last=(k==15).
  - On blk_valid&&blk_ready: k++ and credit++.
  - If blk_last is accepted, go to DRAIN.
  - blk_valid may deassert only after acceptance or when credit is full. Descriptor fields stay stable while blk_valid=1 and not accepted.
- DRAIN:
  - blk_valid=0.
  - When credit==0 (including the same cycle it reaches 0): pulse mb_done=1 for one cycle, go to IDLE.
  - mb_ready rises in the cycle after mb_done; there is no overlap with the next macroblock.
- Credit update per cycle: credit_next = credit + accept − xform_done.
  - A simultaneous accept and done leaves credit unchanged.
- xform_done with credit==0:
  - Ignored (credit does not underflow); err_sticky set.
  - This includes xform_done arriving in IDLE or LOAD.
- mb_valid outside IDLE: ignored, since mb_ready=0.
- blk_start arithmetic (8-bit, no overflow possible):
  - Raster: row=k[3:2], col=k[1:0].
  - Double-Z: row={k[3],k[1]}, col={k[2],k[0]}.
  - blk_start = row*64 + col*4.
- Output timing:
  - blk_* outputs are combinational decodes of registered state/k/credit; they have no combinational path from blk_ready.
  - mb_done, mb_load, mb_ready and busy are registered.
- Latency:
  - Handshake to first blk_valid: 2 cycles.
  - With blk_ready=1 and MAX_OUTSTANDING credit never exhausted, 16 descriptors are issued in 16 consecutive cycles.

Decomposition:
- Package tc_pkg:
  - State enum typedef (IDLE/LOAD/ISSUE/DRAIN).
  - Constants BLKS_PER_MB=16, MB_WIDTH=16, BLK_DIM=4.
  - Scan-order encoding constants ORDER_RASTER=0, ORDER_ZSCAN=1.
- Sub-module tc_scan_addr (purely combinational):
  - Maps (k, order) to blk_start.
  - Reused by the later reconstruction/reassembly stage.

Test Plan:
1. Reset then raster macroblock, blk_ready=1, xform_done 3 cycles after each accept, MAX_OUTSTANDING=2:
   - mb_load one cycle after the handshake.
   - blk_start sequence 0,4,8,12,64,68,...,204; blk_valid stalls whenever credit=2.
   - Exactly one mb_done after the 16th xform_done.
2. Double-Z order:
   - blk_start sequence 0,4,64,68,8,12,72,76,128,132,192,196,136,140,200,204.
   - blk_first only on idx 0, blk_last only on idx 15.
3. Backpressure: blk_ready toggles 0/1 randomly.
   - Descriptor fields are stable while blk_valid=1 and blk_ready=0.
   - No index is skipped or repeated.
4. Simultaneous accept and xform_done with credit=1:
   - credit stays 1; the following issue proceeds without a stall.
5. Spurious xform_done in IDLE:
   - err_sticky goes 1, credit stays 0, no mb_done.
   - The next macroblock still completes normally.
6. rst_n=0 asserted after 7 accepts:
   - Next cycle: busy=0, blk_valid=0, mb_ready=1, no mb_done.
   - A fresh macroblock restarts at blk_start=0.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared types and constants for the transform-coding front end:
// scheduler states, macroblock geometry and scan-order encodings.
package tc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ISSUE = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int BLKS_PER_MB = 16;
  localparam int MB_WIDTH    = 16;
  localparam int BLK_DIM     = 4;

  localparam logic ORDER_RASTER = 1'b0;
  localparam logic ORDER_ZSCAN  = 1'b1;

endpackage

// File: rtl/tc_scan_addr.sv
// Maps a scan position and scan order to the pixel offset of the 4x4 block's
// top-left sample inside the 16x16 macroblock; also used by reassembly.
module tc_scan_addr
  import tc_pkg::*;
(
  input  logic [3:0] k,
  input  logic       order,
  output logic [7:0] blk_start
);

  logic [1:0] row;
  logic [1:0] col;

  always_comb begin
    row = k[3:2];
    col = k[1:0];
    // Double-Z interleaves the index bits: odd bits pick the row, even bits the column.
    if (order == ORDER_ZSCAN) begin
      row = {k[3], k[1]};
      col = {k[2], k[0]};
    end
    blk_start = 8'({6'd0, row}) * 8'(MB_WIDTH * BLK_DIM)
              + 8'({6'd0, col}) * 8'(BLK_DIM);
  end

endmodule

// File: rtl/tc_block_scheduler.sv
// Macroblock scheduler: loads one 16x16 macroblock, issues its 16 4x4 blocks
// under a credit limit, and reports completion once every block has returned.
//   state | meaning
//   IDLE  | waiting for a macroblock handshake
//   LOAD  | one-cycle load strobe to the datapath, scan index reset
//   ISSUE | issuing descriptors while credit is available
//   DRAIN | all blocks issued, waiting for outstanding transforms
module tc_block_scheduler
  import tc_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mb_valid,
  output logic       mb_ready,
  input  logic       order_sel,
  output logic       mb_load,
  output logic       blk_valid,
  input  logic       blk_ready,
  output logic [3:0] blk_idx,
  output logic [7:0] blk_start,
  output logic       blk_first,
  output logic       blk_last,
  input  logic       xform_done,
  output logic       mb_done,
  output logic       busy,
  output logic       err_sticky
);

  localparam int                CNT_W      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0]  CREDIT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0]  CREDIT_ONE = CNT_W'(1);
  localparam logic [3:0]        LAST_IDX   = 4'(BLKS_PER_MB - 1);

  state_t           state_q, state_d;
  logic [3:0]       k_q, k_d;
  logic [CNT_W-1:0] credit_q, credit_d;
  logic             order_q, order_d;
  logic             mb_load_q, mb_done_q, mb_ready_q, busy_q, err_q;
  logic             issuing, accept, done_ok, done_bad, drain_done;
  logic [7:0]       scan_start;

  assign issuing  = (state_q == ISSUE) && (credit_q < CREDIT_MAX);
  assign accept   = issuing && blk_ready;
  assign done_ok  = xform_done && (credit_q != '0);
  assign done_bad = xform_done && (credit_q == '0);

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    order_d    = order_q;
    credit_d   = credit_q;
    drain_done = 1'b0;
    if (accept)  credit_d = credit_d + CREDIT_ONE;
    if (done_ok) credit_d = credit_d - CREDIT_ONE;
    case (state_q)
      IDLE: begin
        if (mb_valid && mb_ready_q) begin
          order_d = order_sel;
          state_d = LOAD;
        end
      end
      LOAD: begin
        k_d     = '0;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (accept) begin
          k_d = k_q + 4'd1;
          if (k_q == LAST_IDX) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Completion also fires in the cycle the final done empties the credit.
        if (credit_d == '0) begin
          drain_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      k_q        <= '0;
      credit_q   <= '0;
      order_q    <= ORDER_RASTER;
      mb_load_q  <= 1'b0;
      mb_done_q  <= 1'b0;
      mb_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      credit_q   <= credit_d;
      order_q    <= order_d;
      mb_load_q  <= (state_d == LOAD);
      mb_done_q  <= drain_done;
      // Hold off the next macroblock for the cycle that carries mb_done.
      mb_ready_q <= (state_d == IDLE) && !drain_done;
      busy_q     <= (state_d != IDLE);
      if (done_bad) err_q <= 1'b1;
    end
  end

  tc_scan_addr u_scan_addr (
    .k         (k_q),
    .order     (order_q),
    .blk_start (scan_start)
  );

  assign blk_valid  = issuing;
  assign blk_idx    = (state_q == ISSUE) ? k_q : 4'd0;
  assign blk_start  = (state_q == ISSUE) ? scan_start : 8'd0;
  assign blk_first  = (state_q == ISSUE) && (k_q == 4'd0);
  assign blk_last   = (state_q == ISSUE) && (k_q == LAST_IDX);
  assign mb_load    = mb_load_q;
  assign mb_done    = mb_done_q;
  assign mb_ready   = mb_ready_q;
  assign busy       = busy_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_tc_block_scheduler.sv
// Directed bench for tc_block_scheduler with MAX_OUTSTANDING=2: scan tables,
// credit stalls, backpressure, spurious completions and mid-macroblock reset.
module tb_tc_block_scheduler;

  logic       clk;
  logic       rst_n;
  logic       mb_valid;
  logic       mb_ready;
  logic       order_sel;
  logic       mb_load;
  logic       blk_valid;
  logic       blk_ready;
  logic [3:0] blk_idx;
  logic [7:0] blk_start;
  logic       blk_first;
  logic       blk_last;
  logic       xform_done;
  logic       mb_done;
  logic       busy;
  logic       err_sticky;

  int checks = 0;
  int errors = 0;

  int rs_tab[16] = '{0, 4, 8, 12, 64, 68, 72, 76, 128, 132, 136, 140, 192, 196, 200, 204};
  int zs_tab[16] = '{0, 4, 64, 68, 8, 12, 72, 76, 128, 132, 192, 196, 136, 140, 200, 204};

  tc_block_scheduler #(.MAX_OUTSTANDING(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mb_valid   (mb_valid),
    .mb_ready   (mb_ready),
    .order_sel  (order_sel),
    .mb_load    (mb_load),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .blk_idx    (blk_idx),
    .blk_start  (blk_start),
    .blk_first  (blk_first),
    .blk_last   (blk_last),
    .xform_done (xform_done),
    .mb_done    (mb_done),
    .busy       (busy),
    .err_sticky (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One macroblock; xform_done returns 'delay' cycles after each accept.
  // ready_mode 0 holds blk_ready high, 1 randomises it. abort_after>0 returns
  // right after that many accepts without finishing the macroblock.
  task automatic run_mb(input bit order, input int ready_mode, input int delay,
                        input int abort_after, output int stalls);
    int n_acc = 0, n_done = 0, cyc = 0, last_done_cyc = -10, exp_credit = 0, exp_start;
    int due[$];
    bit got_done = 0, br, dn, acc, exp_valid, prev_hold = 0;
    logic [3:0] p_idx;
    logic [7:0] p_start;
    logic p_first, p_last;
    stalls = 0;
    checks++;
    if (mb_ready !== 1'b1) begin
      errors++; $display("FAIL hs_ready got=%b exp=1", mb_ready);
    end
    mb_valid = 1'b1; order_sel = order;
    @(posedge clk); #1;
    mb_valid = 1'b0; order_sel = ~order;
    checks++;
    if (mb_load !== 1'b1 || blk_valid !== 1'b0 || mb_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL load_cycle load=%b valid=%b ready=%b busy=%b exp 1/0/0/1",
               mb_load, blk_valid, mb_ready, busy);
    end
    @(posedge clk); #1;
    while (!got_done && cyc < 400) begin
      if (mb_done === 1'b1) begin
        got_done = 1;
        checks++;
        if (n_done != 16 || cyc != last_done_cyc + 1 || mb_ready !== 1'b0) begin
          errors++;
          $display("FAIL mb_done_timing cyc=%0d dones=%0d ready=%b exp cyc=%0d dones=16 ready=0",
                   cyc, n_done, mb_ready, last_done_cyc + 1);
        end
      end else begin
        exp_valid = (n_acc < 16) && (exp_credit < 2);
        checks++;
        if (blk_valid !== exp_valid) begin
          errors++;
          $display("FAIL blk_valid cyc=%0d got=%b exp=%b credit=%0d", cyc, blk_valid, exp_valid, exp_credit);
        end
        if (n_acc < 16 && blk_valid !== 1'b1) stalls++;
        if (blk_valid === 1'b1) begin
          exp_start = order ? zs_tab[n_acc] : rs_tab[n_acc];
          checks++;
          if (blk_idx !== n_acc[3:0] || blk_start !== exp_start[7:0] ||
              blk_first !== (n_acc == 0) || blk_last !== (n_acc == 15)) begin
            errors++;
            $display("FAIL descriptor idx=%0d start=%0d first=%b last=%b exp idx=%0d start=%0d",
                     blk_idx, blk_start, blk_first, blk_last, n_acc, exp_start);
          end
          if (prev_hold) begin
            checks++;
            if (blk_idx !== p_idx || blk_start !== p_start || blk_first !== p_first || blk_last !== p_last) begin
              errors++;
              $display("FAIL stable_hold idx=%0d start=%0d exp idx=%0d start=%0d",
                       blk_idx, blk_start, p_idx, p_start);
            end
          end
        end
        checks++;
        if (mb_ready !== 1'b0 || busy !== 1'b1 || mb_load !== 1'b0) begin
          errors++;
          $display("FAIL active_flags ready=%b busy=%b load=%b exp 0/1/0", mb_ready, busy, mb_load);
        end
      end
      br = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      dn = (due.size() > 0 && due[0] == cyc);
      if (dn) void'(due.pop_front());
      blk_ready = br; xform_done = dn;
      acc = (blk_valid === 1'b1) && br;
      prev_hold = (blk_valid === 1'b1) && !br;
      p_idx = blk_idx; p_start = blk_start; p_first = blk_first; p_last = blk_last;
      if (acc) begin n_acc++; due.push_back(cyc + delay); end
      if (dn) begin n_done++; last_done_cyc = cyc; end
      exp_credit = exp_credit + int'(acc) - int'(dn);
      @(posedge clk); #1;
      cyc++;
      if (abort_after > 0 && n_acc == abort_after) return;
    end
    blk_ready = 1'b0; xform_done = 1'b0;
    checks++;
    if (!got_done) begin
      errors++; $display("FAIL mb_timeout accepts=%0d dones=%0d exp 16/16", n_acc, n_done);
    end else if (mb_done !== 1'b0 || mb_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_done done=%b ready=%b busy=%b exp 0/1/0", mb_done, mb_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mb_valid = 1'b0; order_sel = 1'b0; blk_ready = 1'b0; xform_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (mb_ready !== 1'b1 || mb_load !== 1'b0 || mb_done !== 1'b0 || blk_valid !== 1'b0 ||
        busy !== 1'b0 || err_sticky !== 1'b0 || blk_first !== 1'b0 || blk_last !== 1'b0 ||
        blk_idx !== 4'd0 || blk_start !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs ready=%b load=%b done=%b valid=%b busy=%b err=%b first=%b last=%b idx=%0d start=%0d exp ready=1 rest 0",
               mb_ready, mb_load, mb_done, blk_valid, busy, err_sticky, blk_first, blk_last, blk_idx, blk_start);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_raster();
    int st;
    run_mb(1'b0, 0, 3, 0, st);
    checks++;
    if (st == 0 || err_sticky !== 1'b0) begin
      errors++; $display("FAIL raster_stall stalls=%0d err=%b exp stalls>0 err=0", st, err_sticky);
    end
  endtask

  task automatic test_zscan();
    int st;
    run_mb(1'b1, 0, 3, 0, st);
  endtask

  task automatic test_backpressure();
    int st;
    run_mb(1'b1, 1, 3, 0, st);
    run_mb(1'b0, 1, 2, 0, st);
  endtask

  task automatic test_simul_accept_done();
    int st;
    run_mb(1'b0, 0, 1, 0, st);
    checks++;
    if (st != 0) begin
      errors++; $display("FAIL simul_no_stall stalls=%0d exp=0", st);
    end
  endtask

  task automatic test_spurious_done();
    int st;
    xform_done = 1'b1;
    @(posedge clk); #1;
    xform_done = 1'b0;
    checks++;
    if (err_sticky !== 1'b1 || mb_done !== 1'b0 || mb_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL spurious_flags err=%b done=%b ready=%b busy=%b exp 1/0/1/0", err_sticky, mb_done, mb_ready, busy);
    end
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (mb_done !== 1'b0) begin
        errors++; $display("FAIL spurious_mb_done got=%b exp=0", mb_done);
      end
    end
    run_mb(1'b0, 0, 3, 0, st);
    checks++;
    if (st == 0 || err_sticky !== 1'b1) begin
      errors++; $display("FAIL spurious_after stalls=%0d err=%b exp stalls>0 err=1", st, err_sticky);
    end
  endtask

  task automatic test_reset_mid();
    int st;
    run_mb(1'b0, 0, 3, 7, st);
    rst_n = 1'b0; blk_ready = 1'b0; xform_done = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || blk_valid !== 1'b0 || mb_ready !== 1'b1 || mb_done !== 1'b0 || err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL midreset_flags busy=%b valid=%b ready=%b done=%b err=%b exp 0/0/1/0/0",
               busy, blk_valid, mb_ready, mb_done, err_sticky);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (mb_done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL midreset_idle done=%b busy=%b exp 0/0", mb_done, busy);
      end
    end
    run_mb(1'b0, 0, 3, 0, st);
  endtask

  initial begin
    test_reset();
    test_raster();
    test_zscan();
    test_backpressure();
    test_simul_accept_done();
    test_spurious_done();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
